// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: byte width, default RX FIFO depth and the
// sequencer's lane-mode encodings.
package qspi_pkg;

  localparam int BYTE_W        = 8;
  localparam int QSPI_RX_DEPTH = 16;

  typedef enum logic [1:0] {
    QSPI_MODE_SINGLE = 2'b00,
    QSPI_MODE_DUAL   = 2'b01,
    QSPI_MODE_QUAD   = 2'b10
  } qspi_mode_e;

endpackage : qspi_pkg

// File: rtl/qspi_rx_fifo_ptr.sv
// FIFO pointer with a wrap bit above the address bits; the top bit toggles
// each time the low bits roll over, which separates full from empty.
module qspi_rx_fifo_ptr #(
  parameter int ADDR_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_inc,
  input  logic            i_flush,
  output logic [ADDR_W:0] o_ptr
);

  logic [ADDR_W:0] r_ptr;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values, regardless of the order of the always blocks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_flush) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule : qspi_rx_fifo_ptr

// File: rtl/qspi_rx_fifo.sv
// First-word-fall-through byte FIFO behind the QSPI controller, with level,
// almost-full and sticky overflow. Define QSPI_RX_FIFO_STATS_EN for drop_count/max_level.
module qspi_rx_fifo
  import qspi_pkg::*;
#(
  parameter int DEPTH    = QSPI_RX_DEPTH,
  parameter int ADDR_W   = 4,
  parameter int AFULL_TH = 12
) (
  input  logic              system_clk,
  input  logic              system_reset_n,
  input  logic              write_req,
  input  logic [BYTE_W-1:0] data_qspi2fifo,
  input  logic              flush,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   level,
  output logic              almost_full,
  output logic              full,
  output logic              overflow
`ifdef QSPI_RX_FIFO_STATS_EN
  ,
  output logic [15:0]       drop_count,
  output logic [ADDR_W:0]   max_level
`endif
);

  localparam logic [ADDR_W:0] DEPTH_LV = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_LV = AFULL_TH[ADDR_W:0];

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_level;
  logic              r_almost_full;
  logic              r_full;
  logic              r_overflow;

  logic [ADDR_W:0]   w_wr_ptr;
  logic [ADDR_W:0]   w_rd_ptr;
  logic              w_empty;
  logic              w_full_ptr;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [ADDR_W:0]   w_level_nxt;

  assign w_empty    = (w_wr_ptr == w_rd_ptr);
  assign w_full_ptr = (w_wr_ptr[ADDR_W-1:0] == w_rd_ptr[ADDR_W-1:0]) &&
                      (w_wr_ptr[ADDR_W] != w_rd_ptr[ADDR_W]);

  // A pop never frees space for a same-cycle write; flush swallows both.
  assign w_push = write_req & ~w_full_ptr & ~flush;
  assign w_pop  = rd_ready & ~w_empty & ~flush;
  assign w_drop = write_req & w_full_ptr & ~flush;

  assign w_level_nxt = r_level + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);

  qspi_rx_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .i_clk   (system_clk),
    .i_rst_n (system_reset_n),
    .i_inc   (w_push),
    .i_flush (flush),
    .o_ptr   (w_wr_ptr)
  );

  qspi_rx_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .i_clk   (system_clk),
    .i_rst_n (system_reset_n),
    .i_inc   (w_pop),
    .i_flush (flush),
    .o_ptr   (w_rd_ptr)
  );

  // NOTE: the storage array has no reset; only the pointers define what is
  // valid, so clearing it would cost a reset net on every bit for nothing.
  always_ff @(posedge system_clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr[ADDR_W-1:0]] <= data_qspi2fifo;
    end
  end

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_level       <= '0;
      r_almost_full <= 1'b0;
      r_full        <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (flush) begin
      r_level       <= '0;
      r_almost_full <= 1'b0;
      r_full        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_level       <= w_level_nxt;
      r_almost_full <= (w_level_nxt >= AFULL_LV);
      r_full        <= (w_level_nxt == DEPTH_LV);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef QSPI_RX_FIFO_STATS_EN
  logic [15:0]     r_drop_count;
  logic [ADDR_W:0] r_max_level;

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_drop_count <= '0;
      r_max_level  <= '0;
    end else if (flush) begin
      r_drop_count <= '0;
      r_max_level  <= '0;
    end else begin
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      if (w_level_nxt > r_max_level) begin
        r_max_level <= w_level_nxt;
      end
    end
  end

  assign drop_count = r_drop_count;
  assign max_level  = r_max_level;
`endif

  // Head is forced to zero while empty so the output is defined out of reset.
  assign rd_data     = w_empty ? '0 : r_mem[w_rd_ptr[ADDR_W-1:0]];
  assign rd_valid    = ~w_empty;
  assign level       = r_level;
  assign almost_full = r_almost_full;
  assign full        = r_full;
  assign overflow    = r_overflow;

endmodule : qspi_rx_fifo
